array_mult_ctrl: RTL and testbench

- Initiator-side controller for the n-lane 36-bit array multiplier.
- Accepts operand vectors over a valid/ready stream and drives the multiplier's en/rst/dataa/datab.
- Tracks in-flight operations in an enable-gated shadow valid pipeline.
- Captures results into a small output FIFO and presents them downstream with valid/ready, so backpressure stalls the multiplier and no result is ever lost.

---
 rtl/array_mult_ctrl.sv | 152 +++++++++++++++
 tb/tb_array_mult_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_mult_ctrl.sv
// array_mult_ctrl
//   Initiator-side controller for an N-lane, W-bit pipelined array multiplier.
//   Operand vectors arrive on a valid/ready stream. They are forwarded
//   combinationally to the multiplier, and mul_en advances the multiplier
//   pipeline. A shadow valid pipe tracks which multiplier stages hold live
//   work. Results are captured into a small FIFO and presented downstream
//   with valid/ready. When the FIFO cannot take the result leaving the
//   multiplier, the whole multiplier is frozen, so no result is ever dropped.
//
// Optional build macro: ARRAY_MULT_CTRL_PERF_EN
//   defined   -> perf_issue / perf_stall are live 32-bit wrapping counters
//   undefined -> perf_issue / perf_stall are tied to zero (no flops)
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            one-cycle discard of all in-flight and buffered work
//   in_valid/ready   operand stream handshake
//   in_a, in_b       operand lanes [N-1:0][W-1:0]
//   out_valid/ready  result stream handshake
//   out_result       FIFO head, registered storage
//   busy             anything live in the multiplier or FIFO
//   mul_en, mul_rst  multiplier enable / reset
//   mul_dataa/datab  operands to multiplier (copies of in_a / in_b)
//   mul_result       multiplier output
//   perf_issue       accepted-vector count
//   perf_stall       cycles with in_valid held off by backpressure
module array_mult_ctrl #(
  parameter int N      = 15,
  parameter int W      = 36,
  parameter int LAT    = 3,
  parameter int FDEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0][W-1:0] in_a,
  input  logic [N-1:0][W-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0][W-1:0] out_result,
  output logic                busy,
  output logic                mul_en,
  output logic                mul_rst,
  output logic [N-1:0][W-1:0] mul_dataa,
  output logic [N-1:0][W-1:0] mul_datab,
  input  logic [N-1:0][W-1:0] mul_result,
  output logic [31:0]         perf_issue,
  output logic [31:0]         perf_stall
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);

  logic [LAT-1:0]        vld;
  logic [LAT-1:0]        vld_shift;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [N-1:0][W-1:0]   fifo_mem [FDEPTH];

  logic clear;
  logic vld_tail;
  logic fifo_nonempty;
  logic pop;
  logic room;
  logic safe;
  logic accept;
  logic push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FDEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign clear         = rst | flush;
  assign vld_tail      = vld[LAT-1];
  assign fifo_nonempty = (count != '0);

  // A pop in the same cycle frees the slot the tail result needs, which is
  // what allows full throughput with a full FIFO.
  assign pop  = out_valid & out_ready;
  assign room = (count < CW'(FDEPTH)) | pop;

  // The multiplier only advances when the result leaving it has somewhere
  // to go; otherwise every stage is frozen, including the input stage.
  assign safe     = ~vld_tail | room;
  assign in_ready = safe & ~clear;
  assign mul_en   = safe & (in_valid | (|vld)) & ~clear;
  assign accept   = in_valid & in_ready;
  assign push     = mul_en & vld_tail;

  // Flush does not mask out_valid: a pop coinciding with flush completes
  // for the downstream side even though the FIFO is emptied internally.
  assign out_valid  = fifo_nonempty & ~rst;
  assign busy       = ((|vld) | fifo_nonempty) & ~rst;
  assign out_result = fifo_mem[rd_ptr];

  assign mul_rst   = clear;
  assign mul_dataa = in_a;
  assign mul_datab = in_b;

  generate
    if (LAT == 1) begin : g_vld_one
      assign vld_shift = accept;
    end else begin : g_vld_many
      assign vld_shift = {vld[LAT-2:0], accept};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clear) begin
      vld    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (mul_en) vld <= vld_shift;
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Result storage needs no reset: contents are only observed while
  // out_valid is high, and push is masked during clear.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mul_result;
  end

`ifdef ARRAY_MULT_CTRL_PERF_EN
  logic stall;

  assign stall = in_valid & ~in_ready & ~clear;

  // Cleared by rst only; flush leaves the statistics intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (accept) perf_issue <= perf_issue + 32'd1;
      if (stall)  perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_issue = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_array_mult_ctrl.sv
// Testbench for array_mult_ctrl: multiplier model, scoreboard queue filled
// at accept time and a monitor that pops and compares on every output pop.
module tb_array_mult_ctrl;
  localparam int N      = 15;
  localparam int W      = 36;
  localparam int LAT    = 3;
  localparam int FDEPTH = 2;

  typedef logic [N-1:0][W-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  vec_t        in_a = '0;
  vec_t        in_b = '0;
  logic        in_ready, out_valid, busy, mul_en, mul_rst;
  vec_t        out_result, mul_dataa, mul_datab, mul_result;
  logic [31:0] perf_issue, perf_stall;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int n_wait = 0;
  vec_t exp_q[$];
  int   pop_cyc[$];
  vec_t mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  array_mult_ctrl #(.N(N), .W(W), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .mul_en(mul_en), .mul_rst(mul_rst),
    .mul_dataa(mul_dataa), .mul_datab(mul_datab), .mul_result(mul_result),
    .perf_issue(perf_issue), .perf_stall(perf_stall)
  );

  // Multiplier model: LAT enabled stages, holds when mul_en is low.
  vec_t stg [LAT];
  always @(posedge clk) begin
    if (mul_en) begin
      for (int l = 0; l < N; l++) stg[0][l] <= mul_dataa[l] * mul_datab[l];
      for (int s = 1; s < LAT; s++) stg[s] <= stg[s-1];
    end
  end
  assign mul_result = stg[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the edge following a negedge with valid&ready.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got %h expected none", out_result);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_result !== mon_exp) begin
            n_fail++;
            $display("FAIL result: got %h expected %h", out_result, mon_exp);
          end
        end
      end
    end
  end

  // All driving happens 1 time unit after posedge; in_ready sampled at negedge.
  task automatic send(input vec_t a, input vec_t b);
    bit   acc;
    vec_t e;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) n_wait++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      for (int l = 0; l < N; l++) e[l] = a[l] * b[l];
      exp_q.push_back(e);
      n_acc++;
    end
    in_valid = 1'b0;
  endtask

  // Returns the cycle index (accept cycle = 0) at which out_valid is seen;
  // leaves the caller at the negedge of that cycle.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = t;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t a, b;
    int   lat;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_rst", mul_rst, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Scenario 1: single op 3*5
    a = '0; b = '0; a[0] = 36'd3; b[0] = 36'd5;
    send(a, b);
    wait_out(lat);
    check("s1_latency", lat, LAT + 1);
    check("s1_lane0", out_result[0], 15);
    check("s1_lane14", out_result[14], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("s1_busy_after_pop", busy, 0);
    check("s1_valid_after_pop", out_valid, 0);
    @(posedge clk); #1;

    // Scenario 2: 8 back-to-back ops
    pop_cyc.delete();
    n_wait = 0;
    for (int k = 1; k <= 8; k++) begin
      for (int l = 0; l < N; l++) begin
        a[l] = W'(k + l);
        b[l] = W'(k + 1);
      end
      send(a, b);
    end
    drain();
    check("s2_in_ready_stalls", n_wait, 0);
    check("s2_pop_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) check("s2_pop_span", pop_cyc[7] - pop_cyc[0], 7);

    // Scenario 3: backpressure capacity, with perf counters
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        vec_t da, db;
        for (int k = 1; k <= 10; k++) begin
          for (int l = 0; l < N; l++) begin
            da[l] = W'(k * 3 + l);
            db[l] = W'(k + 2);
          end
          send(da, db);
        end
      end
      begin
        for (int t = 0; t < 100 && n_acc < 5; t++) @(negedge clk);
        check("s3_stall_in_ready", in_ready, 0);
        check("s3_stall_mul_en", mul_en, 0);
        repeat (6) @(posedge clk);
        #1;
        check("s3_accepted_before_release", n_acc, 5);
        out_ready = 1'b1;
      end
    join
    drain();
    check("s3_total_accepted", n_acc, 10);
    check("s3_queue_empty", exp_q.size(), 0);
`ifdef ARRAY_MULT_CTRL_PERF_EN
    check("perf_issue", perf_issue, 10);
    check("perf_stall", perf_stall, 6);
`else
    check("perf_issue", perf_issue, 0);
    check("perf_stall", perf_stall, 0);
`endif

    // Scenario 4: flush with 2 ops in the pipe and 1 in the FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < N; l++) begin
        a[l] = W'(k + 2);
        b[l] = W'(l + 1);
      end
      send(a, b);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("s4_mul_rst_high", mul_rst, 1);
    check("s4_flush_in_ready", in_ready, 0);
    check("s4_flush_out_valid", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("s4_mul_rst_low", mul_rst, 0);
    check("s4_out_valid", out_valid, 0);
    check("s4_busy", busy, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = '0; b = '0; a[0] = 36'd7; b[0] = 36'd6;
    send(a, b);
    wait_out(lat);
    check("s4_latency", lat, LAT + 1);
    check("s4_lane0", out_result[0], 42);
    @(posedge clk); #1;

    // Scenario 5: reset for 2 cycles with the FIFO full
    out_ready = 1'b0;
    for (int k = 0; k < LAT + FDEPTH; k++) begin
      for (int l = 0; l < N; l++) begin
        a[l] = W'(k + 9);
        b[l] = W'(l + 4);
      end
      send(a, b);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("s5_in_ready", in_ready, 0);
      check("s5_mul_en", mul_en, 0);
      check("s5_out_valid", out_valid, 0);
      check("s5_mul_rst", mul_rst, 1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("s5_post_out_valid", out_valid, 0);
    check("s5_post_busy", busy, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = '0; b = '0;
    a[0] = 36'hF_FFFF_FFFF; b[0] = 36'd2;
    a[5] = 36'd11;          b[5] = 36'd13;
    send(a, b);
    wait_out(lat);
    check("s5_latency", lat, LAT + 1);
    check("s5_lane0_wrap", out_result[0], 36'hF_FFFF_FFFE);
    check("s5_lane5", out_result[5], 143);
    @(posedge clk); #1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
